// File: rtl/fir4_chan_sched.sv
// fir4_chan_sched: four sample channels share one 4-tap moving-sum FIR.
// A round-robin arbiter grants at most one channel per cycle. Each channel's
// three-sample history lives in a small register file. The granted sample
// passes through a two-stage adder tree, and every result is tagged with the
// channel it came from. Output backpressure stalls the entire pipeline.
module fir4_chan_sched #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic           clr,
  output logic           out_valid,
  output logic [W+1:0]   out_data,
  output logic [1:0]     out_chan,
  input  logic           out_ready
);

  // Widening adds; the operands are unsigned, so the extra bit always holds the carry.
  function automatic logic [W:0] add_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [W+1:0] add_part(input logic [W:0] a, input logic [W:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [1:0]   ptr;
  logic [W-1:0] h1 [N];
  logic [W-1:0] h2 [N];
  logic [W-1:0] h3 [N];

  logic [N-1:0] grant;
  logic [1:0]   gnt_idx;
  logic [1:0]   cand;
  logic         found;
  logic         en;
  logic         accept;
  logic [W-1:0] x_p0;

  logic [W:0]   sum_a_p1;
  logic [W:0]   sum_b_p1;
  logic [1:0]   chan_p1;
  logic         vld_p1;

  // Round-robin search: the first requesting channel at or after ptr wins
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    cand    = ptr;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + 2'(k);
      if (!found && in_valid[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = (en & ~clr & ~reset) ? grant : '0;
  assign accept   = |in_ready;
  assign x_p0     = in_data[32'(gnt_idx) * W +: W];

  // Per-channel history: shift on accept, wipe all channels on clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
        h3[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < N; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
        h3[i] <= '0;
      end
    end else if (accept) begin
      h3[gnt_idx] <= h2[gnt_idx];
      h2[gnt_idx] <= h1[gnt_idx];
      h1[gnt_idx] <= x_p0;
    end
  end

  // Stage 1: two partial sums plus the channel tag; the pointer moves past the winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      sum_a_p1 <= '0;
      sum_b_p1 <= '0;
      chan_p1  <= '0;
      ptr      <= '0;
    end else if (en) begin
      vld_p1 <= accept;
      if (accept) begin
        sum_a_p1 <= add_pair(x_p0, h1[gnt_idx]);
        sum_b_p1 <= add_pair(h2[gnt_idx], h3[gnt_idx]);
        chan_p1  <= gnt_idx;
        ptr      <= gnt_idx + 2'd1;
      end
    end
  end

  // Stage 2: final sum, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      out_data  <= add_part(sum_a_p1, sum_b_p1);
      out_chan  <= chan_p1;
    end
  end

endmodule

// File: tb/tb_fir4_chan_sched.sv
// Testbench for fir4_chan_sched: scenario tasks compare the DUT against a
// queue-based reference model of the scheduler and the 4-sample moving sum.
module tb_fir4_chan_sched;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [17:0] out_data;
  logic [1:0]  out_chan;

  int errors = 0;
  int checks = 0;

  fir4_chan_sched #(.W(W), .N(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr(clr), .out_valid(out_valid),
    .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model. mq holds produced results in order; age counts the
  // advancing edges since the result's sample was accepted. A result becomes
  // visible once it has aged by one edge.
  typedef struct { logic [1:0] c; logic [17:0] d; int age; } res_t;
  res_t        mq[$];
  logic [15:0] mh [4][3];
  int          mptr;

  task automatic model_clear();
    mq.delete();
    for (int c = 0; c < 4; c++) for (int j = 0; j < 3; j++) mh[c][j] = '0;
    mptr = 0;
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
    return 4'b0;
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic set_ch(input int c, input logic [15:0] v);
    in_data[c*16 +: 16] = v;
  endtask

  // One cycle. The caller drives inputs just after a negedge. This task samples
  // the DUT and computes the model's expectations before the posedge, advances
  // the model at the edge, and returns at the next negedge.
  task automatic tick(output logic [3:0] g_rdy, output logic [3:0] e_rdy,
                      output logic g_v, output logic e_v,
                      output logic [17:0] g_d, output logic [17:0] e_d,
                      output logic [1:0] g_c, output logic [1:0] e_c);
    logic        en;
    int          g;
    logic [15:0] x;
    logic [17:0] y;
    res_t        tmp;
    #1;
    e_v   = (mq.size() > 0) && (mq[0].age >= 1);
    e_d   = e_v ? mq[0].d : 18'd0;
    e_c   = e_v ? mq[0].c : 2'd0;
    en    = !(e_v && !out_ready);
    e_rdy = (en && !clr && !reset) ? rr_pick(in_valid, mptr) : 4'b0;
    g_rdy = in_ready;
    g_v   = out_valid;
    g_d   = out_data;
    g_c   = out_chan;
    @(posedge clk);
    if (en) begin
      if (e_v) tmp = mq.pop_front();
      foreach (mq[i]) mq[i].age = mq[i].age + 1;
      g = oh2i(e_rdy);
      if (g >= 0) begin
        x = in_data[g*16 +: 16];
        y = 18'(x) + 18'(mh[g][0]) + 18'(mh[g][1]) + 18'(mh[g][2]);
        mq.push_back('{c: 2'(g), d: y, age: 0});
        mh[g][2] = mh[g][1];
        mh[g][1] = mh[g][0];
        mh[g][0] = x;
        mptr = (g + 1) % 4;
      end
    end
    if (clr) for (int c = 0; c < 4; c++) for (int j = 0; j < 3; j++) mh[c][j] = '0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = '0;
    clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 18'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    in_valid = '0;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_impulse();
    logic [3:0] gr, er; logic gv, ev; logic [17:0] gd, ed; logic [1:0] gc, ec;
    logic gvs [9]; logic [17:0] gds [9]; logic [1:0] gcs [9];
    logic [17:0] want [5];
    want = '{18'd5, 18'd5, 18'd5, 18'd5, 18'd0};
    out_ready = 1'b1;
    for (int t = 0; t < 9; t++) begin
      in_valid = (t < 5) ? 4'b0001 : 4'b0000;
      set_ch(0, (t == 0) ? 16'd5 : 16'd0);
      tick(gr, er, gv, ev, gd, ed, gc, ec);
      gvs[t] = gv; gds[t] = gd; gcs[t] = gc;
      checks++; if (gr !== er) begin errors++; $display("FAIL imp_ready t=%0d got=%b exp=%b", t, gr, er); end
      checks++; if (gv !== ev || (ev && (gd !== ed || gc !== ec))) begin
        errors++; $display("FAIL imp_model t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, gv, gd, gc, ev, ed, ec);
      end
    end
    for (int t = 0; t < 9; t++) begin
      checks++;
      if (gvs[t] !== (t >= 2 && t <= 6)) begin
        errors++; $display("FAIL imp_latency t=%0d got_valid=%b exp=%b", t, gvs[t], (t >= 2 && t <= 6));
      end else if (t >= 2 && t <= 6 && (gds[t] !== want[t-2] || gcs[t] !== 2'd0)) begin
        errors++; $display("FAIL imp_value t=%0d got=%0d/ch%0d exp=%0d/ch0", t, gds[t], gcs[t], want[t-2]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gr, er; logic gv, ev; logic [17:0] gd, ed; logic [1:0] gc, ec;
    int cnt [4]; int n; int rx;
    apply_reset();
    cnt = '{0, 0, 0, 0}; rx = 0;
    for (int i = 0; i < 4; i++) set_ch(i, 16'(i + 1));
    for (int t = 0; t < 19; t++) begin
      in_valid = (t < 16) ? 4'hF : 4'h0;
      tick(gr, er, gv, ev, gd, ed, gc, ec);
      checks++; if (gr !== er) begin errors++; $display("FAIL rr_ready t=%0d got=%b exp=%b", t, gr, er); end
      if (t < 16) begin
        checks++; if (gr !== 4'(1 << (t % 4))) begin errors++; $display("FAIL rr_order t=%0d got=%b exp=%b", t, gr, 4'(1 << (t % 4))); end
      end
      checks++; if (gv !== ev || (ev && (gd !== ed || gc !== ec))) begin
        errors++; $display("FAIL rr_model t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, gv, gd, gc, ev, ed, ec);
      end
      if (gv === 1'b1) begin
        rx++;
        cnt[gc] = cnt[gc] + 1;
        n = (cnt[gc] < 4) ? cnt[gc] : 4;
        checks++; if (gd !== 18'(n * (gc + 1))) begin errors++; $display("FAIL rr_ramp ch=%0d got=%0d exp=%0d", gc, gd, n * (gc + 1)); end
      end
    end
    checks++; if (rx !== 16) begin errors++; $display("FAIL rr_count got=%0d exp=16", rx); end
  endtask

  task automatic test_backpressure();
    logic [3:0] gr, er; logic gv, ev; logic [17:0] gd, ed; logic [1:0] gc, ec;
    logic [17:0] hold_d; logic [1:0] hold_c;
    int cnt [4]; int n; int rx;
    apply_reset();
    cnt = '{0, 0, 0, 0}; rx = 0; hold_d = '0; hold_c = '0;
    for (int i = 0; i < 4; i++) set_ch(i, 16'(i + 1));
    for (int t = 0; t < 23; t++) begin
      in_valid  = (t < 20) ? 4'hF : 4'h0;
      out_ready = !(t >= 8 && t <= 10);
      tick(gr, er, gv, ev, gd, ed, gc, ec);
      checks++; if (gr !== er) begin errors++; $display("FAIL bp_ready t=%0d got=%b exp=%b", t, gr, er); end
      checks++; if (gv !== ev || (ev && (gd !== ed || gc !== ec))) begin
        errors++; $display("FAIL bp_model t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, gv, gd, gc, ev, ed, ec);
      end
      if (t == 8) begin hold_d = gd; hold_c = gc; end
      if (t >= 8 && t <= 10) begin
        checks++; if (gr !== 4'b0 || gv !== 1'b1 || gd !== hold_d || gc !== hold_c) begin
          errors++; $display("FAIL bp_hold t=%0d got=%b/%b/%0d/%0d exp=0000/1/%0d/%0d", t, gr, gv, gd, gc, hold_d, hold_c);
        end
      end
      if (gv === 1'b1 && out_ready) begin
        rx++;
        cnt[gc] = cnt[gc] + 1;
        n = (cnt[gc] < 4) ? cnt[gc] : 4;
        checks++; if (gd !== 18'(n * (gc + 1))) begin errors++; $display("FAIL bp_ramp ch=%0d got=%0d exp=%0d", gc, gd, n * (gc + 1)); end
      end
    end
    out_ready = 1'b1;
    checks++; if (rx !== 17) begin errors++; $display("FAIL bp_count got=%0d exp=17", rx); end
  endtask

  task automatic test_saturation();
    logic [3:0] gr, er; logic gv, ev; logic [17:0] gd, ed; logic [1:0] gc, ec;
    logic [17:0] outs [$]; logic [1:0] chs [$];
    apply_reset();
    set_ch(2, 16'hFFFF);
    for (int t = 0; t < 7; t++) begin
      in_valid = (t < 4) ? 4'b0100 : 4'b0000;
      tick(gr, er, gv, ev, gd, ed, gc, ec);
      checks++; if (gr !== er) begin errors++; $display("FAIL sat_ready t=%0d got=%b exp=%b", t, gr, er); end
      checks++; if (gv !== ev || (ev && (gd !== ed || gc !== ec))) begin
        errors++; $display("FAIL sat_model t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, gv, gd, gc, ev, ed, ec);
      end
      if (gv === 1'b1) begin outs.push_back(gd); chs.push_back(gc); end
    end
    checks++;
    if (outs.size() != 4) begin
      errors++; $display("FAIL sat_count got=%0d exp=4", outs.size());
    end else if (outs[3] !== 18'h3FFFC || chs[3] !== 2'd2) begin
      errors++; $display("FAIL sat_max got=%0d/ch%0d exp=262140/ch2", outs[3], chs[3]);
    end
  endtask

  task automatic test_clr();
    logic [3:0] gr, er; logic gv, ev; logic [17:0] gd, ed; logic [1:0] gc, ec;
    logic [17:0] outs [$];
    logic [15:0] seq [8];
    apply_reset();
    seq = '{16'd10, 16'd20, 16'd30, 16'd99, 16'd7, 16'd0, 16'd0, 16'd0};
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 5) ? 4'b0010 : 4'b0000;
      clr = (t == 3);
      set_ch(1, seq[t]);
      tick(gr, er, gv, ev, gd, ed, gc, ec);
      checks++; if (gr !== er) begin errors++; $display("FAIL clr_ready t=%0d got=%b exp=%b", t, gr, er); end
      if (t == 3) begin
        checks++; if (gr !== 4'b0) begin errors++; $display("FAIL clr_nogrant got=%b exp=0000", gr); end
      end
      checks++; if (gv !== ev || (ev && (gd !== ed || gc !== ec))) begin
        errors++; $display("FAIL clr_model t=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", t, gv, gd, gc, ev, ed, ec);
      end
      if (gv === 1'b1) outs.push_back(gd);
    end
    clr = 1'b0;
    checks++;
    if (outs.size() != 4) begin
      errors++; $display("FAIL clr_count got=%0d exp=4", outs.size());
    end else if (outs[2] !== 18'd60 || outs[3] !== 18'd7) begin
      errors++; $display("FAIL clr_values got=%0d,%0d exp=60,7", outs[2], outs[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] gr, er; logic gv, ev; logic [17:0] gd, ed; logic [1:0] gc, ec;
    apply_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 16'(i + 1));
    in_valid = 4'hF;
    for (int t = 0; t < 3; t++) begin
      tick(gr, er, gv, ev, gd, ed, gc, ec);
      checks++; if (gr !== er) begin errors++; $display("FAIL rm_ready t=%0d got=%b exp=%b", t, gr, er); end
    end
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got=%b exp=1", out_valid); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 18'd0) begin errors++; $display("FAIL rm_data got=%0d exp=0", out_data); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL rm_ready_low got=%b exp=0000", in_ready); end
    model_clear();
    @(negedge clk);
    #2;
    reset = 1'b0;
    in_valid = 4'b1001;
    set_ch(0, 16'd9);
    set_ch(3, 16'd5);
    tick(gr, er, gv, ev, gd, ed, gc, ec);
    checks++; if (gr !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", gr); end
    in_valid = 4'b0000;
    tick(gr, er, gv, ev, gd, ed, gc, ec);
    tick(gr, er, gv, ev, gd, ed, gc, ec);
    checks++; if (gv !== 1'b1 || gd !== 18'd9 || gc !== 2'd0) begin
      errors++; $display("FAIL rm_first got=%b/%0d/ch%0d exp=1/9/ch0", gv, gd, gc);
    end
    checks++; if (gv !== ev || (ev && (gd !== ed || gc !== ec))) begin
      errors++; $display("FAIL rm_model got=%b/%0d/%0d exp=%b/%0d/%0d", gv, gd, gc, ev, ed, ec);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_impulse();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir4_chan_sched.md
# fir4_chan_sched

Round-robin scheduler that time-shares one 4-tap moving-sum FIR datapath among four independent input channels. It holds each channel's three-sample history in a register file and grants at most one channel's sample per cycle. The granted sample is pushed through a two-stage pipelined adder tree, and each result is emitted tagged with its source channel. It sits between the per-channel sample sources and the downstream result consumer, replacing four dedicated FIR instances.

## Interface
- W, 16, sample width (unsigned)
- N, 4, number of channels (fixed at 4; channel id is 2 bits)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  N  per-channel sample available
- in_data  input  N*W  channel i sample at bits [i*W +: W]
- in_ready  output  N  one-hot grant; sample i accepted on an edge where in_valid[i] & in_ready[i]
- clr  input  1  synchronous clear of all channel histories
- out_valid  output  1  result valid
- out_data  output  W+2  y = x[n]+x[n-1]+x[n-2]+x[n-3] for the tagged channel
- out_chan  output  2  channel id of out_data
- out_ready  input  1  consumer accepts result on an edge where out_valid & out_ready

## Operation
- State per channel i: h1[i], h2[i], h3[i] (W bits each) hold the previous three accepted samples. Reset value is 0.
- Priority pointer ptr (2 bits), reset value 0. The search order is ptr, ptr+1, … mod 4. The first channel in that order with in_valid high is granted.
- Stall: stall = out_valid & ~out_ready. The advance enable is en = ~stall.
- in_ready = one-hot grant when en & ~clr & ~reset. It is all-zero otherwise.
  - in_ready depends combinationally on in_valid. Sources must not make in_valid depend on in_ready.
- On accept of channel g with sample x:
  - Stage 1 registers p0 = x + h1[g] and p1 = h2[g] + h3[g] (W+1 bits each), plus chan = g and v1 = 1.
  - The history shifts: h3[g] <= h2[g], h2[g] <= h1[g], h1[g] <= x.
  - ptr <= g+1 mod 4.
- No accept while en is high: v1 <= 0, and ptr holds.
- Stage 2 / output, when en is high: out_data <= p0 + p1 (W+2 bits, zero-extended, no overflow possible), out_chan <= stage-1 chan, out_valid <= v1.
- While stall is high, stage 1, the output registers, ptr and all histories hold.
- Arithmetic is unsigned, and the maximum result 4*(2^W - 1) fits in W+2 bits.
- Back-to-back accepts on the same channel are legal. The second accept reads the history written at the first accept's edge.
- clr handling:
  - Zeroes all 12 history registers on the edge.
  - Suppresses grants that cycle.
  - Does not disturb stage 1, the output or ptr. In-flight results complete with their captured values.
  - clr during a stall has the same effect.
- reset (asynchronous) clears everything immediately: histories, ptr, v1, p0, p1, stage-1 chan, out_valid, out_data, out_chan. in_ready is forced to 0 while reset is high.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, in_ready=0.
- Latency: a sample accepted at edge k appears on out_data/out_valid after edge k+1, when no stall occurs.
- Throughput is one result per cycle with out_ready held high. Each stall cycle delays the pipeline by exactly one cycle, with no data lost or duplicated.
- Fairness: a continuously requesting channel is granted within 4 accept cycles.
- A result presented while out_valid is high is held stable until the edge on which out_ready is sampled high.
- Removing reset asynchronously is allowed. The first grant can occur on the first edge after reset falls.

## Test plan
- Impulse, channel 0:
  - Stimulus: feed 5, 0, 0, 0, 0 on channel 0 with out_ready=1.
  - Required: outputs 5, 5, 5, 5, 0, all with out_chan=0, the first appearing 2 edges after the first accept.
- Round robin:
  - Stimulus: all four in_valid held high, channel i sending constant i+1, out_ready=1.
  - Required: grant order 0, 1, 2, 3, 0, … Channel i outputs ramp (i+1), 2(i+1), 3(i+1), then steady 4(i+1).
- Backpressure:
  - Stimulus: the round-robin test with out_ready low for 3 cycles mid-stream.
  - Required: out_data and out_chan held constant; in_ready=0 throughout; the sequence resumes with no loss or duplication.
- Saturation:
  - Stimulus: channel 2 sends 0xFFFF four times.
  - Required: 4th output = 0x3FFFC (262140), out_chan=2.
- clr:
  - Stimulus: channel 1 history = 10, 20, 30, then assert clr for one cycle with in_valid[1] high, then send 7.
  - Required: no grant in the clr cycle; the next output for channel 1 is 7. Results already in flight are unaffected.
- Reset mid-stream:
  - Stimulus: assert reset asynchronously while out_valid=1 and stage 1 is full.
  - Required: out_valid, out_data and in_ready drop to 0 immediately; after release the first channel-0 sample 9 outputs 9; ptr restarts at 0.
